// File: rtl/adpll_chan_seq.sv
// Channel-hop sequencer in front of the ADPLL controller: parks in PD, programs FCW/mode, supervises lock.
// Optional build macro ADPLL_CHSEQ_RELOCK_EN: automatic re-hop to the same channel after lock loss.
//
// state     | meaning
// IDLE      | no hop in flight, adpll_mode = PD, ready for a request
// PARK      | adpll_mode forced to PD for SETTLE cycles before programming
// PROG      | target FCW and mode applied for one cycle
// WAIT_LOCK | waiting for channel_lock, timeout/retry supervision
// LOCKED    | channel locked, request or release accepted
// FAIL      | one-cycle error report after the retry budget is spent
module adpll_chan_seq #(
    parameter int FCWW   = 26,
    parameter int TOUTW  = 12,
    parameter int SETTLE = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [FCWW-1:0]  req_fcw,
    input  logic             req_tx,
    input  logic             release_req,
    input  logic [TOUTW-1:0] timeout_lim,
    input  logic [1:0]       max_retry,
    input  logic             channel_lock,
    output logic [FCWW-1:0]  fcw,
    output logic [1:0]       adpll_mode,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             err,
    output logic             lock_lost
);

    localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] PARK_LOAD = SW'(SETTLE - 1);
    localparam logic [1:0] MODE_PD = 2'd0;
    localparam logic [1:0] MODE_RX = 2'd2;
    localparam logic [1:0] MODE_TX = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PARK      = 3'd1,
        PROG      = 3'd2,
        WAIT_LOCK = 3'd3,
        LOCKED    = 3'd4,
        FAIL      = 3'd5
    } state_t;

    state_t           state;
    logic [SW-1:0]    park_cnt;
    logic [TOUTW-1:0] wait_cnt;
    logic [1:0]       retry_cnt;
    logic [FCWW-1:0]  tgt_fcw;
    logic [1:0]       tgt_mode;
    logic             accept;
    logic             timeout_hit;

    assign req_ready   = (state == IDLE) || (state == LOCKED);
    assign accept      = req_valid && req_ready;
    assign timeout_hit = (timeout_lim != '0) && (wait_cnt == timeout_lim - TOUTW'(1));

    // Controller samples its inputs on the rising edge, so this block moves on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            park_cnt   <= '0;
            wait_cnt   <= '0;
            retry_cnt  <= '0;
            tgt_fcw    <= '0;
            tgt_mode   <= MODE_PD;
            fcw        <= '0;
            adpll_mode <= MODE_PD;
            busy       <= 1'b0;
            locked     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            lock_lost  <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            if (accept) begin
                // A request in LOCKED wins over a simultaneous release or lock loss.
                tgt_fcw    <= req_fcw;
                tgt_mode   <= req_tx ? MODE_TX : MODE_RX;
                err        <= 1'b0;
                lock_lost  <= 1'b0;
                retry_cnt  <= '0;
                park_cnt   <= PARK_LOAD;
                adpll_mode <= MODE_PD;
                busy       <= 1'b1;
                locked     <= 1'b0;
                state      <= PARK;
            end else begin
                unique case (state)
                    IDLE: begin
                    end
                    PARK: begin
                        if (park_cnt == '0) begin
                            fcw        <= tgt_fcw;
                            adpll_mode <= tgt_mode;
                            state      <= PROG;
                        end else begin
                            park_cnt <= park_cnt - SW'(1);
                        end
                    end
                    PROG: begin
                        wait_cnt <= '0;
                        state    <= WAIT_LOCK;
                    end
                    WAIT_LOCK: begin
                        if (channel_lock) begin
                            busy   <= 1'b0;
                            locked <= 1'b1;
                            done   <= 1'b1;
                            state  <= LOCKED;
                        end else if (timeout_hit) begin
                            adpll_mode <= MODE_PD;
                            if (retry_cnt < max_retry) begin
                                retry_cnt <= retry_cnt + 2'd1;
                                park_cnt  <= PARK_LOAD;
                                state     <= PARK;
                            end else begin
                                busy  <= 1'b0;
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= FAIL;
                            end
                        end else if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + TOUTW'(1);
                        end
                    end
                    LOCKED: begin
                        if (release_req) begin
                            adpll_mode <= MODE_PD;
                            locked     <= 1'b0;
                            state      <= IDLE;
                        end else if (!channel_lock) begin
                            lock_lost <= 1'b1;
`ifdef ADPLL_CHSEQ_RELOCK_EN
                            locked     <= 1'b0;
                            retry_cnt  <= '0;
                            park_cnt   <= PARK_LOAD;
                            adpll_mode <= MODE_PD;
                            busy       <= 1'b1;
                            state      <= PARK;
`endif
                        end
                    end
                    FAIL: begin
                        state <= IDLE;
                    end
                    default: begin
                        adpll_mode <= MODE_PD;
                        busy       <= 1'b0;
                        locked     <= 1'b0;
                        state      <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adpll_chan_seq.sv
// Bench for adpll_chan_seq: directed and randomized hops against a timeline model of each hop.
// Honours ADPLL_CHSEQ_RELOCK_EN for the lock-loss expectations.
module tb_adpll_chan_seq;

    localparam int FCWW   = 26;
    localparam int TOUTW  = 12;
    localparam int SETTLE = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             req_valid;
    logic             req_ready;
    logic [FCWW-1:0]  req_fcw;
    logic             req_tx;
    logic             release_req;
    logic [TOUTW-1:0] timeout_lim;
    logic [1:0]       max_retry;
    logic             channel_lock;
    logic [FCWW-1:0]  fcw;
    logic [1:0]       adpll_mode;
    logic             busy;
    logic             locked;
    logic             done;
    logic             err;
    logic             lock_lost;

    int checks = 0;
    int errors = 0;
    logic [FCWW-1:0] cur_fcw;

    adpll_chan_seq #(.FCWW(FCWW), .TOUTW(TOUTW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_fcw(req_fcw), .req_tx(req_tx),
        .release_req(release_req), .timeout_lim(timeout_lim), .max_retry(max_retry),
        .channel_lock(channel_lock), .fcw(fcw), .adpll_mode(adpll_mode), .busy(busy),
        .locked(locked), .done(done), .err(err), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] observed();
        return 64'({fcw, adpll_mode, busy, locked, done, err, req_ready, lock_lost});
    endfunction

    function automatic logic [63:0] pack(input logic [FCWW-1:0] f, input logic [1:0] m, input logic b,
                                         input logic lk, input logic d, input logic e, input logic r,
                                         input logic lost);
        return 64'({f, m, b, lk, d, e, r, lost});
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected outputs t enabled edges after the accept edge of a hop.
    function automatic logic [63:0] exp_vec(input int t, input int t_end, input bit lock_ok, input int rl,
                                            input logic [1:0] tm, input logic [FCWW-1:0] tgt,
                                            input logic [FCWW-1:0] old, input bit lost);
        logic [FCWW-1:0] f;
        int o;
        f = (t < SETTLE) ? old : tgt;
        if (t < t_end) begin
            o = lock_ok ? t : t % rl;
            return pack(f, (o < SETTLE) ? 2'd0 : tm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lost);
        end else if (lock_ok) begin
            return pack(f, tm, 1'b0, 1'b1, (t == t_end), 1'b0, 1'b1, lost);
        end else begin
            return pack(f, 2'd0, 1'b0, 1'b0, (t == t_end), 1'b1, (t != t_end), lost);
        end
    endfunction

    // Lock is driven D wait-edges after PROG; lock wins if it lands no later than the timeout edge.
    task automatic run_timeline(input logic [1:0] tm, input logic [FCWW-1:0] tgt, input logic [FCWW-1:0] old,
                                input int lim, input int rmax, input int d, input int gap_at,
                                input int gap_len, input bit lost, output bit lock_ok);
        int rl;
        int t_end;
        rl      = SETTLE + 1 + lim;
        lock_ok = (lim == 0) || (d + 1 <= lim);
        t_end   = lock_ok ? SETTLE + 2 + d : (rmax + 1) * rl;
        for (int t = 0; t <= t_end + 1; t++) begin
            if (t > 0) begin
                channel_lock = lock_ok && (t >= t_end);
                if (gap_len > 0 && t == gap_at) begin
                    en = 1'b0;
                    for (int g = 0; g < gap_len; g++) begin
                        step();
                        check($sformatf("en_gap_%0d", g), observed(),
                              exp_vec(t - 1, t_end, lock_ok, rl, tm, tgt, old, lost));
                    end
                    en = 1'b1;
                end
                step();
            end
            check($sformatf("hop_t%0d", t), observed(), exp_vec(t, t_end, lock_ok, rl, tm, tgt, old, lost));
        end
    endtask

    task automatic hop(input logic [FCWW-1:0] tgt, input bit tx, input int lim, input int rmax, input int d,
                       input int gap_at, input int gap_len, input bit rel, output bit lock_ok);
        check("ready_before_req", 64'(req_ready), 64'(1));
        timeout_lim  = TOUTW'(lim);
        max_retry    = 2'(rmax);
        req_fcw      = tgt;
        req_tx       = tx;
        req_valid    = 1'b1;
        release_req  = rel;
        channel_lock = 1'b0;
        step();
        req_valid   = 1'b0;
        release_req = 1'b0;
        req_fcw     = FCWW'($urandom);
        req_tx      = ~tx;
        run_timeline(tx ? 2'd3 : 2'd2, tgt, cur_fcw, lim, rmax, d, gap_at, gap_len, 1'b0, lock_ok);
        cur_fcw = tgt;
    endtask

    task automatic do_release();
        release_req = 1'b1;
        step();
        release_req = 1'b0;
        check("release_to_idle", observed(), pack(cur_fcw, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    initial begin
        bit ok;
        logic [FCWW-1:0] nf;
        bit ntx;
        logic [1:0] tm;
        rst          = 1'b1;
        en           = 1'b1;
        req_valid    = 1'b0;
        req_fcw      = '0;
        req_tx       = 1'b0;
        release_req  = 1'b0;
        timeout_lim  = '0;
        max_retry    = '0;
        channel_lock = 1'b0;
        cur_fcw      = '0;

        // Reset state
        step();
        step();
        check("reset_values", observed(), pack('0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        rst = 1'b0;
        step();
        check("idle_after_reset", observed(), pack('0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

        // RX hop, lock 500 cycles after PROG, wait forever
        hop(26'h0A0C000, 1'b0, 0, 0, 500, 0, 0, 1'b0, ok);
        do_release();

        // TX hop, timeout 100, two retries, no lock -> FAIL after three rounds
        hop(FCWW'($urandom), 1'b1, 100, 2, 1000, 0, 0, 1'b0, ok);
        check("fail_outcome", 64'(ok), 64'(0));

        // Lock, then a new request together with release: request wins
        hop(FCWW'($urandom), 1'b1, 0, 0, 10, 0, 0, 1'b0, ok);
        hop(FCWW'($urandom), 1'b0, 0, 0, 20, 0, 0, 1'b1, ok);

        // Lock loss in LOCKED
        tm = 2'd2;
        channel_lock = 1'b0;
        step();
`ifdef ADPLL_CHSEQ_RELOCK_EN
        check("lock_loss_rehop", observed(), pack(cur_fcw, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        run_timeline(tm, cur_fcw, cur_fcw, 0, 0, 7, 0, 0, 1'b1, ok);
`else
        check("lock_loss_hold", observed(), pack(cur_fcw, tm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
        channel_lock = 1'b1;
        step();
        check("lock_lost_sticky", observed(), pack(cur_fcw, tm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
`endif

        // en low for 50 cycles mid WAIT_LOCK with timeout 10: counter resumes
        hop(FCWW'($urandom), 1'b0, 10, 0, 1000, SETTLE + 1 + 5, 50, 1'b0, ok);

        // Async reset in WAIT_LOCK
        nf = FCWW'($urandom);
        timeout_lim = '0;
        req_fcw = nf;
        req_tx = 1'b1;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (SETTLE + 5) step();
        check("pre_rst_wait", observed(), pack(nf, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        #2 rst = 1'b1;
        #1 check("async_rst", observed(), pack('0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        #2 rst = 1'b0;
        cur_fcw = '0;
        step();
        check("post_rst_idle", observed(), pack('0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));

        // Randomized hops
        for (int i = 0; i < 12; i++) begin
            int lim;
            nf  = FCWW'($urandom);
            ntx = 1'($urandom_range(0, 1));
            lim = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
            hop(nf, ntx, lim, int'($urandom_range(0, 3)), int'($urandom_range(0, 60)), 0, 0,
                1'($urandom_range(0, 1)), ok);
            if (ok && $urandom_range(0, 1) == 1) do_release();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
